// File: rtl/ga_fitness_fsm_pkg.sv
// Shared GA definitions: index widths and the fitness sequencer state encoding.
package ga_fitness_fsm_pkg;

  localparam int B_MAX   = 128;
  localparam int B_IDX_W = $clog2(B_MAX);
  localparam int P_MAX   = 64;
  localparam int P_IDX_W = $clog2(P_MAX);
  localparam int WD_W    = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FLUSH  = 3'd1,
    ST_POP    = 3'd2,
    ST_START  = 3'd3,
    ST_WAIT   = 3'd4,
    ST_NEXT   = 3'd5,
    ST_REPORT = 3'd6,
    ST_DONE   = 3'd7
  } ga_fit_fsm_st_e;

endpackage

// File: rtl/ga_fitness_fsm_if.sv
// Queue / sample-buffer / datapath / selection signals seen by the fitness sequencer.
interface ga_fitness_fsm_if;
  import ga_fitness_fsm_pkg::*;

  logic               queue_rd_pls;
  logic [B_IDX_W-1:0] vd_rd_idx;
  logic               fit_flush_pls;
  logic               fit_start_pls;
  logic               fit_next_pls;
  logic               algo_done_pls;
  logic               sel_valid;
  logic               sel_ready;
  logic               sel_last;

  // Sequencer side
  modport master (
    output queue_rd_pls, vd_rd_idx, fit_flush_pls, fit_start_pls, fit_next_pls,
    output sel_valid, sel_last,
    input  algo_done_pls, sel_ready
  );

  // Datapath / queue / selection side
  modport slave (
    input  queue_rd_pls, vd_rd_idx, fit_flush_pls, fit_start_pls, fit_next_pls,
    input  sel_valid, sel_last,
    output algo_done_pls, sel_ready
  );

endinterface

// File: rtl/ga_fitness_fsm_gen_wd_cnt.sv
// Generic watchdog counter: clear restarts the count, enable advances it,
// expire_o pulses so that a registered error lands exactly LIMIT cycles
// after the clearing cycle (the clearing cycle itself counts as 1).
module gen_wd_cnt #(
  parameter int CNT_W = 4,
  parameter int LIMIT = 15
) (
  input  logic clk,
  input  logic rstn,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] EXP_AT  = CNT_W'(LIMIT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: restart on clear, saturating increment while enabled
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = CNT_W'(1);
    end else if (en_i && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  assign expire_o = en_i && !clr_i && (cnt_q == EXP_AT);

  // Count register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/ga_fitness_fsm.sv
// Fitness control sequencer for one GA generation: pops chromosomes, walks the
// V/D sample buffer issuing flush/start/next pulses, reports each score to
// selection with valid/ready and signals generation done. All outputs registered.
module ga_fitness_fsm
  import ga_fitness_fsm_pkg::*;
#(
  parameter int WD_CYC = 15
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               sw_rst,
  input  logic               gen_start_pls,
  input  logic [B_IDX_W-1:0] cfg_b_num,
  input  logic [P_IDX_W-1:0] cfg_p_num,
  output logic               gen_done_pls,
  output logic               busy,
  output logic               wd_err,
  ga_fitness_fsm_if.master   bus
);

  ga_fit_fsm_st_e     state_q;
  logic [B_IDX_W-1:0] b_num_q;
  logic [P_IDX_W-1:0] p_num_q;
  logic [B_IDX_W-1:0] b_cnt_q;
  logic [P_IDX_W-1:0] p_cnt_q;
  logic [B_IDX_W-1:0] vd_idx_q;
  logic               flush_q;
  logic               pop_q;
  logic               start_q;
  logic               next_q;
  logic               sel_valid_q;
  logic               sel_last_q;
  logic               gen_done_q;
  logic               busy_q;
  logic               wd_err_q;

  logic wd_clr;
  logic wd_en;
  logic wd_expire;

  // The watchdog restarts in every start/next pulse cycle and runs only while
  // a sample is outstanding.
  assign wd_clr = sw_rst || (state_q == ST_START) || (state_q == ST_NEXT);
  assign wd_en  = (state_q == ST_WAIT);

  gen_wd_cnt #(
    .CNT_W (WD_W),
    .LIMIT (WD_CYC)
  ) u_wd (
    .clk      (clk),
    .rstn     (rstn),
    .clr_i    (wd_clr),
    .en_i     (wd_en),
    .expire_o (wd_expire)
  );

  // Sequencer: state, counters and every registered output
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      b_num_q     <= '0;
      p_num_q     <= '0;
      b_cnt_q     <= '0;
      p_cnt_q     <= '0;
      vd_idx_q    <= '0;
      flush_q     <= 1'b0;
      pop_q       <= 1'b0;
      start_q     <= 1'b0;
      next_q      <= 1'b0;
      sel_valid_q <= 1'b0;
      sel_last_q  <= 1'b0;
      gen_done_q  <= 1'b0;
      busy_q      <= 1'b0;
      wd_err_q    <= 1'b0;
    end else if (sw_rst) begin
      // Soft reset drops straight to idle without a flush; the next
      // generation always flushes the datapath first anyway.
      state_q     <= ST_IDLE;
      b_num_q     <= '0;
      p_num_q     <= '0;
      b_cnt_q     <= '0;
      p_cnt_q     <= '0;
      vd_idx_q    <= '0;
      flush_q     <= 1'b0;
      pop_q       <= 1'b0;
      start_q     <= 1'b0;
      next_q      <= 1'b0;
      sel_valid_q <= 1'b0;
      sel_last_q  <= 1'b0;
      gen_done_q  <= 1'b0;
      busy_q      <= 1'b0;
      wd_err_q    <= 1'b0;
    end else begin
      flush_q    <= 1'b0;
      pop_q      <= 1'b0;
      start_q    <= 1'b0;
      next_q     <= 1'b0;
      gen_done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (gen_start_pls) begin
            b_num_q  <= cfg_b_num;
            p_num_q  <= cfg_p_num;
            p_cnt_q  <= '0;
            wd_err_q <= 1'b0;
            flush_q  <= 1'b1;
            busy_q   <= 1'b1;
            state_q  <= ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          pop_q    <= 1'b1;
          vd_idx_q <= '0;
          state_q  <= ST_POP;
        end
        ST_POP: begin
          start_q <= 1'b1;
          b_cnt_q <= '0;
          state_q <= ST_START;
        end
        ST_START: begin
          state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          // A completed sample wins over a watchdog expiry in the same cycle.
          if (bus.algo_done_pls) begin
            if (b_cnt_q == b_num_q) begin
              sel_valid_q <= 1'b1;
              sel_last_q  <= (p_cnt_q == p_num_q);
              state_q     <= ST_REPORT;
            end else begin
              b_cnt_q  <= b_cnt_q + B_IDX_W'(1);
              vd_idx_q <= b_cnt_q + B_IDX_W'(1);
              next_q   <= 1'b1;
              state_q  <= ST_NEXT;
            end
          end else if (wd_expire) begin
            wd_err_q <= 1'b1;
            flush_q  <= 1'b1;
            busy_q   <= 1'b0;
            state_q  <= ST_IDLE;
          end
        end
        ST_NEXT: begin
          state_q <= ST_WAIT;
        end
        ST_REPORT: begin
          if (bus.sel_ready) begin
            sel_valid_q <= 1'b0;
            sel_last_q  <= 1'b0;
            if (sel_last_q) begin
              gen_done_q <= 1'b1;
              state_q    <= ST_DONE;
            end else begin
              p_cnt_q <= p_cnt_q + P_IDX_W'(1);
              flush_q <= 1'b1;
              state_q <= ST_FLUSH;
            end
          end
        end
        ST_DONE: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.queue_rd_pls  = pop_q;
  assign bus.vd_rd_idx     = vd_idx_q;
  assign bus.fit_flush_pls = flush_q;
  assign bus.fit_start_pls = start_q;
  assign bus.fit_next_pls  = next_q;
  assign bus.sel_valid     = sel_valid_q;
  assign bus.sel_last      = sel_last_q;
  assign gen_done_pls      = gen_done_q;
  assign busy              = busy_q;
  assign wd_err            = wd_err_q;

endmodule

// File: tb/tb_ga_fitness_fsm.sv
// Directed bench for ga_fitness_fsm with a fixed-latency datapath model.
module tb_ga_fitness_fsm;
  import ga_fitness_fsm_pkg::*;

  localparam int L  = 5;
  localparam int WD = 15;

  logic               clk = 1'b0;
  logic               rstn;
  logic               sw_rst;
  logic               gen_start_pls;
  logic [B_IDX_W-1:0] cfg_b_num;
  logic [P_IDX_W-1:0] cfg_p_num;
  logic               gen_done_pls;
  logic               busy;
  logic               wd_err;

  ga_fitness_fsm_if bus();

  ga_fitness_fsm #(.WD_CYC(WD)) dut (
    .clk           (clk),
    .rstn          (rstn),
    .sw_rst        (sw_rst),
    .gen_start_pls (gen_start_pls),
    .cfg_b_num     (cfg_b_num),
    .cfg_p_num     (cfg_p_num),
    .gen_done_pls  (gen_done_pls),
    .busy          (busy),
    .wd_err        (wd_err),
    .bus           (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  int cyc = 0;
  int n_flush, n_pop, n_start, n_next, n_hs, n_vrise, n_done, n_overlap, n_order;
  int gs_cyc, start_cyc, first_vrise_cyc, wd_cyc;
  logic [B_IDX_W-1:0] idx_q[$];
  logic               last_q[$];
  bit flushed = 1'b0;
  bit v_prev  = 1'b0;
  bit wd_prev = 1'b0;

  bit alg_en   = 1'b1;
  int alg_pend = 0;

  // Datapath model: algo_done_pls exactly L cycles after each start/next pulse
  always @(negedge clk) begin
    if (sw_rst === 1'b1) alg_pend = 0;
    else if (alg_en && (bus.fit_start_pls === 1'b1 || bus.fit_next_pls === 1'b1)) alg_pend = L + 1;
    else if (alg_pend > 0) alg_pend--;
    bus.algo_done_pls = (alg_pend == 1);
  end

  // Event monitor
  always @(negedge clk) begin
    cyc++;
    if (gen_start_pls === 1'b1) gs_cyc = cyc;
    if (sw_rst === 1'b1) flushed = 1'b0;
    if ((int'(bus.fit_flush_pls) + int'(bus.queue_rd_pls) + int'(bus.fit_start_pls) + int'(bus.fit_next_pls)) > 1) n_overlap++;
    if (bus.fit_flush_pls === 1'b1) begin n_flush++; flushed = 1'b1; end
    if (bus.queue_rd_pls === 1'b1) n_pop++;
    if (bus.fit_start_pls === 1'b1) begin
      n_start++; start_cyc = cyc;
      if (!flushed) n_order++;
      flushed = 1'b0;
      idx_q.push_back(bus.vd_rd_idx);
    end
    if (bus.fit_next_pls === 1'b1) begin n_next++; idx_q.push_back(bus.vd_rd_idx); end
    if (bus.sel_valid === 1'b1 && !v_prev) begin
      n_vrise++;
      if (first_vrise_cyc < 0) first_vrise_cyc = cyc;
    end
    v_prev = (bus.sel_valid === 1'b1);
    if (bus.sel_valid === 1'b1 && bus.sel_ready === 1'b1) begin n_hs++; last_q.push_back(bus.sel_last); end
    if (gen_done_pls === 1'b1) n_done++;
    if (wd_err === 1'b1 && !wd_prev) wd_cyc = cyc;
    wd_prev = (wd_err === 1'b1);
  end

  task automatic clr_counts();
    n_flush = 0; n_pop = 0; n_start = 0; n_next = 0; n_hs = 0; n_vrise = 0;
    n_done = 0; n_order = 0; first_vrise_cyc = -1; wd_cyc = -1;
    idx_q.delete(); last_q.delete();
  endtask

  task automatic pulse_gen(input int b, input int p);
    @(posedge clk); #1;
    cfg_b_num = B_IDX_W'(b);
    cfg_p_num = P_IDX_W'(p);
    gen_start_pls = 1'b1;
    @(posedge clk); #1;
    gen_start_pls = 1'b0;
  endtask

  task automatic wait_done(input int maxc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      if (n_done > 0) begin ok = 1'b1; break; end
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [8:0] outs;
    rstn = 1'b0; sw_rst = 1'b0; gen_start_pls = 1'b0;
    cfg_b_num = '0; cfg_p_num = '0; bus.sel_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    outs = {bus.queue_rd_pls, bus.fit_flush_pls, bus.fit_start_pls, bus.fit_next_pls,
            bus.sel_valid, bus.sel_last, gen_done_pls, busy, wd_err};
    n_tests++; if (outs !== 9'b0) begin n_fail++; $display("FAIL reset_outs_in_reset: got %b expected 0", outs); end
    n_tests++; if (bus.vd_rd_idx !== '0) begin n_fail++; $display("FAIL reset_idx_in_reset: got %0d expected 0", bus.vd_rd_idx); end
    rstn = 1'b1;
    @(posedge clk); #1;
    outs = {bus.queue_rd_pls, bus.fit_flush_pls, bus.fit_start_pls, bus.fit_next_pls,
            bus.sel_valid, bus.sel_last, gen_done_pls, busy, wd_err};
    n_tests++; if (outs !== 9'b0) begin n_fail++; $display("FAIL reset_outs_after: got %b expected 0", outs); end
    n_tests++; if (bus.vd_rd_idx !== '0) begin n_fail++; $display("FAIL reset_idx_after: got %0d expected 0", bus.vd_rd_idx); end
  endtask

  task automatic test_main();
    bit ok;
    logic [B_IDX_W-1:0] exp_idx;
    clr_counts();
    pulse_gen(3, 1);
    wait_done(400, ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL main_timeout: got no gen_done_pls expected one"); end
    n_tests++; if (n_flush != 2) begin n_fail++; $display("FAIL main_flush: got %0d expected 2", n_flush); end
    n_tests++; if (n_pop != 2) begin n_fail++; $display("FAIL main_pop: got %0d expected 2", n_pop); end
    n_tests++; if (n_start != 2) begin n_fail++; $display("FAIL main_start: got %0d expected 2", n_start); end
    n_tests++; if (n_next != 6) begin n_fail++; $display("FAIL main_next: got %0d expected 6", n_next); end
    n_tests++;
    if (idx_q.size() != 8) begin
      n_fail++; $display("FAIL main_idx_len: got %0d expected 8", idx_q.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        exp_idx = B_IDX_W'(i % 4);
        n_tests++;
        if (idx_q[i] !== exp_idx) begin n_fail++; $display("FAIL main_idx[%0d]: got %0d expected %0d", i, idx_q[i], exp_idx); end
      end
    end
    n_tests++; if (n_hs != 2) begin n_fail++; $display("FAIL main_handshakes: got %0d expected 2", n_hs); end
    n_tests++;
    if (last_q.size() != 2) begin
      n_fail++; $display("FAIL main_last_len: got %0d expected 2", last_q.size());
    end else if (last_q[0] !== 1'b0 || last_q[1] !== 1'b1) begin
      n_fail++; $display("FAIL main_sel_last: got %b%b expected 01", last_q[0], last_q[1]);
    end
    n_tests++; if (n_done != 1) begin n_fail++; $display("FAIL main_gen_done: got %0d expected 1", n_done); end
    n_tests++; if (first_vrise_cyc - gs_cyc != 27) begin n_fail++; $display("FAIL main_latency: got %0d expected 27", first_vrise_cyc - gs_cyc); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL main_busy_end: got %b expected 0", busy); end
    n_tests++; if (n_order != 0) begin n_fail++; $display("FAIL main_flush_order: got %0d expected 0", n_order); end
  endtask

  task automatic test_single();
    bit ok;
    clr_counts();
    pulse_gen(0, 0);
    wait_done(200, ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL single_timeout: got no gen_done_pls expected one"); end
    n_tests++; if (n_flush != 1 || n_pop != 1 || n_start != 1) begin n_fail++; $display("FAIL single_pulses: got flush %0d pop %0d start %0d expected 1 1 1", n_flush, n_pop, n_start); end
    n_tests++; if (n_next != 0) begin n_fail++; $display("FAIL single_next: got %0d expected 0", n_next); end
    n_tests++; if (n_hs != 1 || last_q.size() != 1) begin n_fail++; $display("FAIL single_hs: got %0d expected 1", n_hs); end
    else if (last_q[0] !== 1'b1) begin n_fail++; $display("FAIL single_last: got %b expected 1", last_q[0]); end
    n_tests++; if (first_vrise_cyc - gs_cyc != 9) begin n_fail++; $display("FAIL single_latency: got %0d expected 9", first_vrise_cyc - gs_cyc); end
    n_tests++; if (n_done != 1) begin n_fail++; $display("FAIL single_gen_done: got %0d expected 1", n_done); end
  endtask

  task automatic test_ready_stall();
    bit ok;
    bit seen;
    int bad;
    logic first_last;
    clr_counts();
    bus.sel_ready = 1'b0;
    pulse_gen(0, 1);
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.sel_valid === 1'b1) begin seen = 1'b1; break; end
    end
    first_last = bus.sel_last;
    n_tests++; if (!seen) begin n_fail++; $display("FAIL stall_valid_timeout: got no sel_valid expected one"); end
    n_tests++; if (first_last !== 1'b0) begin n_fail++; $display("FAIL stall_first_last: got %b expected 0", first_last); end
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.sel_valid !== 1'b1 || bus.sel_last !== 1'b0 || bus.fit_flush_pls !== 1'b0 ||
          bus.queue_rd_pls !== 1'b0 || bus.fit_start_pls !== 1'b0 || bus.fit_next_pls !== 1'b0 ||
          gen_done_pls !== 1'b0) bad++;
    end
    n_tests++; if (bad != 0) begin n_fail++; $display("FAIL stall_hold: got %0d unstable cycles expected 0", bad); end
    @(posedge clk); #1;
    bus.sel_ready = 1'b1;
    @(posedge clk); #1;
    n_tests++; if (bus.fit_flush_pls !== 1'b1) begin n_fail++; $display("FAIL stall_flush_after_ready: got %b expected 1", bus.fit_flush_pls); end
    n_tests++; if (bus.sel_valid !== 1'b0) begin n_fail++; $display("FAIL stall_valid_drop: got %b expected 0", bus.sel_valid); end
    wait_done(200, ok);
    n_tests++; if (!ok || n_hs != 2) begin n_fail++; $display("FAIL stall_complete: got done %0d hs %0d expected 1 2", n_done, n_hs); end
  endtask

  task automatic test_watchdog();
    bit ok;
    bit seen;
    logic flush_at_err, busy_at_err;
    clr_counts();
    alg_en = 1'b0;
    pulse_gen(2, 0);
    seen = 1'b0; flush_at_err = 1'b0; busy_at_err = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (wd_err === 1'b1) begin
        seen = 1'b1; flush_at_err = bus.fit_flush_pls; busy_at_err = busy; break;
      end
    end
    repeat (3) @(posedge clk);
    #1;
    n_tests++; if (!seen) begin n_fail++; $display("FAIL wd_timeout: got no wd_err expected 1"); end
    n_tests++; if (wd_cyc - start_cyc != WD) begin n_fail++; $display("FAIL wd_delay: got %0d expected %0d", wd_cyc - start_cyc, WD); end
    n_tests++; if (flush_at_err !== 1'b1) begin n_fail++; $display("FAIL wd_flush: got %b expected 1", flush_at_err); end
    n_tests++; if (busy_at_err !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL wd_busy: got %b/%b expected 0", busy_at_err, busy); end
    n_tests++; if (n_flush != 2) begin n_fail++; $display("FAIL wd_flush_count: got %0d expected 2", n_flush); end
    n_tests++; if (n_vrise != 0 || n_done != 0) begin n_fail++; $display("FAIL wd_no_report: got valid %0d done %0d expected 0 0", n_vrise, n_done); end
    n_tests++; if (wd_err !== 1'b1) begin n_fail++; $display("FAIL wd_sticky: got %b expected 1", wd_err); end
    alg_en = 1'b1;
    pulse_gen(0, 0);
    n_tests++; if (wd_err !== 1'b0) begin n_fail++; $display("FAIL wd_clear_on_start: got %b expected 0", wd_err); end
    wait_done(200, ok);
    n_tests++; if (!ok || n_done != 1) begin n_fail++; $display("FAIL wd_recover: got done %0d expected 1", n_done); end
  endtask

  task automatic test_sw_rst();
    bit ok;
    bit seen;
    logic [8:0] outs;
    clr_counts();
    pulse_gen(3, 0);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.fit_start_pls === 1'b1) begin seen = 1'b1; break; end
    end
    repeat (2) @(posedge clk);
    #1;
    pulse_gen(0, 0);
    repeat (2) @(posedge clk);
    #1;
    n_tests++; if (busy !== 1'b1 || n_flush != 1) begin n_fail++; $display("FAIL swr_start_while_busy: got busy %b flush %0d expected 1 1", busy, n_flush); end
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.fit_next_pls === 1'b1) begin seen = seen && 1'b1; break; end
      if (i == 39) seen = 1'b0;
    end
    n_tests++; if (!seen) begin n_fail++; $display("FAIL swr_reach_sample2: got no next pulse expected one"); end
    @(posedge clk); #1;
    sw_rst = 1'b1;
    @(posedge clk); #1;
    outs = {bus.queue_rd_pls, bus.fit_flush_pls, bus.fit_start_pls, bus.fit_next_pls,
            bus.sel_valid, bus.sel_last, gen_done_pls, busy, wd_err};
    n_tests++; if (outs !== 9'b0) begin n_fail++; $display("FAIL swr_outs: got %b expected 0", outs); end
    n_tests++; if (bus.vd_rd_idx !== '0) begin n_fail++; $display("FAIL swr_idx: got %0d expected 0", bus.vd_rd_idx); end
    sw_rst = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    clr_counts();
    pulse_gen(1, 0);
    wait_done(200, ok);
    n_tests++; if (!ok || n_done != 1) begin n_fail++; $display("FAIL swr_regen_done: got %0d expected 1", n_done); end
    n_tests++; if (n_flush != 1 || n_pop != 1 || n_start != 1 || n_next != 1) begin n_fail++; $display("FAIL swr_regen_pulses: got %0d %0d %0d %0d expected 1 1 1 1", n_flush, n_pop, n_start, n_next); end
    n_tests++; if (idx_q.size() != 2) begin n_fail++; $display("FAIL swr_regen_idx_len: got %0d expected 2", idx_q.size()); end
    else if (idx_q[0] !== B_IDX_W'(0) || idx_q[1] !== B_IDX_W'(1)) begin n_fail++; $display("FAIL swr_regen_idx: got %0d,%0d expected 0,1", idx_q[0], idx_q[1]); end
    n_tests++; if (n_order != 0) begin n_fail++; $display("FAIL swr_flush_order: got %0d expected 0", n_order); end
  endtask

  initial begin
    n_overlap = 0;
    clr_counts();
    test_reset();
    test_main();
    test_single();
    test_ready_stall();
    test_watchdog();
    test_sw_rst();
    n_tests++; if (n_overlap != 0) begin n_fail++; $display("FAIL pulse_exclusive: got %0d overlapping cycles expected 0", n_overlap); end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no completion expected finish");
    $fatal(1, "simulation time limit");
  end

endmodule
